// File: rtl/line_buffer_scheduler_if.sv
// Control/status bundle between the conv2d layer controller, the scheduler and the line buffer.
// The scheduler is the slave side; the controller/line-buffer pair is the master side.
interface line_buffer_scheduler_if #(
    parameter int SIZE_WIDTH = 8,
    parameter int CH_WIDTH   = 9
);
    logic                  Start;
    logic                  Abort;
    logic [SIZE_WIDTH-1:0] IMAGE_SIZE;
    logic [CH_WIDTH-1:0]   CHANNEL_COUNT;
    logic                  Done_1row;
    logic                  Stream_first_row;
    logic                  Stream_mid_row;
    logic                  Stream_last_row;
    logic                  last_channel;
    logic [SIZE_WIDTH-1:0] row_index;
    logic [CH_WIDTH-1:0]   channel_index;
    logic                  Busy;
    logic                  Done;
    logic                  Cfg_err;

    modport master (
        output Start, Abort, IMAGE_SIZE, CHANNEL_COUNT, Done_1row,
        input  Stream_first_row, Stream_mid_row, Stream_last_row, last_channel,
               row_index, channel_index, Busy, Done, Cfg_err
    );

    modport slave (
        input  Start, Abort, IMAGE_SIZE, CHANNEL_COUNT, Done_1row,
        output Stream_first_row, Stream_mid_row, Stream_last_row, last_channel,
               row_index, channel_index, Busy, Done, Cfg_err
    );
endinterface

// File: rtl/line_buffer_scheduler.sv
// Walks the line buffer through N+1 row commands per channel for C channels,
// pacing each command on the previous Done_1row plus ROW_GAP idle cycles.
module line_buffer_scheduler #(
    parameter int SIZE_WIDTH = 8,
    parameter int CH_WIDTH   = 9,
    parameter int ROW_GAP    = 2
) (
    input  logic                     clk,
    input  logic                     Reset,
    line_buffer_scheduler_if.slave   bus
);
    localparam int GW = (ROW_GAP < 2) ? 1 : $clog2(ROW_GAP);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ROW, GAP, DONE} state_t;

    state_t                state, state_nxt;
    logic [SIZE_WIDTH-1:0] n_lat, row;
    logic [CH_WIDTH-1:0]   c_lat, ch;
    logic [GW-1:0]         gap_cnt;
    logic                  cfg_err_q;

    logic   start_ok, row_more, ch_more, gap_last;
    state_t after_row;

    assign start_ok  = bus.Start && (bus.IMAGE_SIZE != '0) && (bus.CHANNEL_COUNT != '0);
    assign row_more  = row < n_lat;
    assign ch_more   = ch < (c_lat - 1'b1);
    assign gap_last  = gap_cnt == GW'(ROW_GAP - 1);
    assign after_row = (ROW_GAP == 0) ? ISSUE : GAP;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            n_lat     <= '0;
            c_lat     <= '0;
            row       <= '0;
            ch        <= '0;
            gap_cnt   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg_err_q <= (state == IDLE) && bus.Start && !start_ok;
            gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            // Abort freezes the counters; a later Start clears them anyway.
            if (!bus.Abort) begin
                if (state == IDLE && start_ok) begin
                    n_lat <= bus.IMAGE_SIZE;
                    c_lat <= bus.CHANNEL_COUNT;
                    row   <= '0;
                    ch    <= '0;
                end else if (state == WAIT_ROW && bus.Done_1row) begin
                    if (row_more) begin
                        row <= row + 1'b1;
                    end else if (ch_more) begin
                        ch  <= ch + 1'b1;
                        row <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt            = state;
        bus.Stream_first_row = 1'b0;
        bus.Stream_mid_row   = 1'b0;
        bus.Stream_last_row  = 1'b0;
        bus.Busy             = (state != IDLE);
        bus.Done             = 1'b0;
        case (state)
            IDLE:     if (start_ok) state_nxt = ISSUE;
            ISSUE: begin
                state_nxt            = WAIT_ROW;
                bus.Stream_first_row = (row == '0);
                bus.Stream_mid_row   = (row != '0) && row_more;
                bus.Stream_last_row  = (row == n_lat);
            end
            WAIT_ROW: if (bus.Done_1row) state_nxt = (row_more || ch_more) ? after_row : DONE;
            GAP:      if (gap_last) state_nxt = ISSUE;
            DONE: begin
                bus.Done  = 1'b1;
                state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
        if (bus.Abort) state_nxt = IDLE;
    end

    assign bus.last_channel  = (state != IDLE) && (ch == c_lat - 1'b1);
    assign bus.row_index     = row;
    assign bus.channel_index = ch;
    assign bus.Cfg_err       = cfg_err_q;
endmodule

// File: doc/line_buffer_scheduler.md
# line_buffer_scheduler

Sequences `input_line_buffer` over a full feature map. For each input channel it issues the single-cycle row commands `Stream_first_row`, `Stream_mid_row` and `Stream_last_row`, waits for `Done_1row` after each command, and flags the final channel with `last_channel`. It sits between the conv2d layer controller (Start/Done) and the line buffer; AXI data movement stays inside the line buffer.

## Interface
Parameters:
- `SIZE_WIDTH`, 8: width of `IMAGE_SIZE` and `row_index`.
- `CH_WIDTH`, 9: width of `CHANNEL_COUNT` and `channel_index`; 256 channels must be representable.
- `ROW_GAP`, 2: idle cycles between a received `Done_1row` and the next row command; 0 is legal.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  begin a map; sampled only in IDLE.
- `Abort`  in  1  return to IDLE from any state at the next edge; no `Done`.
- `IMAGE_SIZE`  in  SIZE_WIDTH  rows per channel (N); latched at accepted Start.
- `CHANNEL_COUNT`  in  CH_WIDTH  channels (C); latched at accepted Start.
- `Done_1row`  in  1  line-buffer pulse: current row command finished.
- `Stream_first_row`  out  1  one-cycle pulse, row 0 of a channel.
- `Stream_mid_row`  out  1  one-cycle pulse, rows 1..N-1.
- `Stream_last_row`  out  1  one-cycle pulse, bottom-padding/flush row.
- `last_channel`  out  1  high for the whole final channel.
- `row_index`  out  SIZE_WIDTH  index of the current command, 0..N.
- `channel_index`  out  CH_WIDTH  current channel, 0..C-1.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse when the map completes.
- `Cfg_err`  out  1  one-cycle pulse when Start is rejected.

## Operation
- States: IDLE, ISSUE, WAIT_ROW, GAP, DONE.
- IDLE: on Start with N≥1 and C≥1, latch the configuration, clear both counters and go to ISSUE.
  - On Start with N=0 or C=0, pulse `Cfg_err` and stay in IDLE.
- ISSUE, exactly one cycle, then WAIT_ROW. The command pulsed depends on `row_index`:
  - 0: first_row.
  - 1..N-1: mid_row.
  - N: last_row.
- Commands per channel: N+1. With N=1 the sequence is first_row then last_row.
- WAIT_ROW: hold until `Done_1row`=1. Then:
  - If `row_index`<N: increment `row_index`; go to GAP, or to ISSUE if ROW_GAP=0.
  - Else, if `channel_index`<C-1: increment `channel_index`, clear `row_index`, go to GAP/ISSUE.
  - Else: go to DONE.
- GAP: count ROW_GAP cycles, then go to ISSUE.
- DONE: pulse `Done` for one cycle, then IDLE.
- `last_channel` = Busy and (`channel_index` == C-1). It stays high through DONE.
- Ignored inputs:
  - `Done_1row` outside WAIT_ROW.
  - Start while Busy.
  - Changes to `IMAGE_SIZE`/`CHANNEL_COUNT` while Busy.
- Abort has priority over every other transition, including Done_1row arriving in the same cycle.
- Counter comparisons use the full latched widths; there is no wrap-around.

## Timing
- Reset (async assert) clears all outputs, counters and the state to IDLE.
- After reset deassertion, the block accepts Start on the first edge.
- Accepted Start at edge k: `Busy`=1 and `Stream_first_row`=1 during cycle k+1.
- `Done_1row` sampled at edge m: the next command pulse is high in cycle m+1+ROW_GAP.
- Final `Done_1row` sampled at edge m: `Done`=1 in cycle m+1 and `Busy`=0 in cycle m+2.
- At most one Stream_* output is high in any cycle. No Stream_* output is high outside ISSUE.
- Reset or Abort mid-row: any Stream_* output clears immediately on the async reset, or on the next edge for Abort. The line buffer is expected to be reset alongside.

## Test plan
- N=4, C=2, ROW_GAP=2, `Done_1row` returned 3 cycles after each command.
  - Required: per channel the sequence first, mid, mid, mid, last (10 commands total).
  - Required: `last_channel` low during channel 0 and high during channel 1.
  - Required: one `Done` pulse; each Done_1row→next-command spacing exactly 3 cycles.
- N=1, C=1, ROW_GAP=0.
  - Required: first_row, last_row, then Done.
  - Required: each command lands the cycle after the preceding Done_1row.
- Start with N=0, then Start with C=0.
  - Required: `Cfg_err` pulsed once each; `Busy` stays 0; no command pulses.
- Stray stimulus during N=4, C=256:
  - Spurious `Done_1row` in GAP/ISSUE: required no extra row advance.
  - Second Start while Busy: required no effect.
  - Required: final `channel_index`=255 and `Done` after 1280 commands.
- Abort during WAIT_ROW of channel 1, row 2:
  - Required: IDLE at the next edge, no `Done`.
  - Required: a subsequent Start restarts at channel 0, row 0.
- `Reset` asserted asynchronously mid-GAP.
  - Required: all outputs 0 with no clock edge.
  - Required: normal restart after release.
